uart_transceiver: RTL and testbench

Full-duplex 8N1/8E1-style UART serial transceiver with one shared oversampling baud generator. It serves two roles: the serial front end of the MIPS debug unit, which loads 32-bit instructions as four bytes sent LSB byte first, and the host-side serial model in system benches. It converts parallel bytes to an asynchronous serial frame and back, with single-cycle strobes on both sides.

---
 rtl/uart_transceiver_pkg.sv | 18 +
 rtl/uart_baud_tick.sv | 27 ++
 rtl/uart_transceiver.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_transceiver.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_transceiver_pkg.sv
// Shared definitions for the UART transceiver: FSM state encoding and bit-timing constants.
package uart_transceiver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int TICKS_PER_BIT = 16;
    localparam int TICK_CNT_W    = $clog2(TICKS_PER_BIT);

    localparam logic [TICK_CNT_W-1:0] TICK_LAST = TICK_CNT_W'(TICKS_PER_BIT - 1);
    localparam logic [TICK_CNT_W-1:0] TICK_HALF = TICK_CNT_W'(TICKS_PER_BIT / 2 - 1);

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversampling tick generator; one o_tick pulse every TICK_DIV clocks.
module uart_baud_tick #(
    parameter int TICK_DIV = 4
) (
    input  logic i_clock,
    input  logic i_reset,
    output logic o_tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] r_count;

    assign o_tick = (r_count == CNT_W'(TICK_DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (o_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART: independent TX and RX FSMs sharing one 16x oversampling tick.
module uart_transceiver
    import uart_transceiver_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int STOP_WIDTH   = 1,
    parameter int PARITY_WIDTH = 1,
    parameter int TICK_DIV     = 4
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_rx_data,
    input  logic                    i_tx_signal,
    input  logic [DATA_WIDTH-1:0]   i_tx_result,
    input  logic [PARITY_WIDTH-1:0] i_parity,
    output logic                    o_rx_done,
    output logic [DATA_WIDTH-1:0]   o_rx_data,
    output logic [PARITY_WIDTH-1:0] o_parity,
    output logic                    o_tx_data,
    output logic                    o_tx_done,
    output logic                    o_tx_available
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + STOP_WIDTH + 1);
    localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0] STOP_LAST = BIT_CNT_W'(STOP_WIDTH - 1);
    localparam uart_state_t AFTER_DATA = (PARITY_WIDTH != 0) ? ST_PARITY : ST_STOP;

    logic w_tick;

    uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_baud_tick (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .o_tick  (w_tick)
    );

    // ---------------- transmitter ----------------
    uart_state_t            r_tx_state, w_tx_state_next;
    logic [TICK_CNT_W-1:0]  r_tx_tick,  w_tx_tick_next;
    logic [BIT_CNT_W-1:0]   r_tx_bit,   w_tx_bit_next;
    logic [DATA_WIDTH-1:0]  r_tx_shift, w_tx_shift_next;
    logic                   r_tx_par,   w_tx_par_next;
    logic                   r_tx_line,  w_tx_line_next;
    logic                   r_tx_done,  w_tx_done_next;
    logic                   r_tx_avail;
    logic                   w_tx_bit_end;

    assign w_tx_bit_end = w_tick && (r_tx_tick == TICK_LAST);

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_tick_next  = w_tick ? r_tx_tick + 1'b1 : r_tx_tick;
        w_tx_bit_next   = r_tx_bit;
        w_tx_shift_next = r_tx_shift;
        w_tx_par_next   = r_tx_par;
        w_tx_done_next  = 1'b0;
        w_tx_line_next  = 1'b1;
        case (r_tx_state)
            ST_IDLE: begin
                w_tx_tick_next = '0;
                w_tx_bit_next  = '0;
                if (i_tx_signal) begin
                    w_tx_shift_next = i_tx_result;
                    w_tx_par_next   = (^i_tx_result) ^ i_parity[0];
                    w_tx_state_next = ST_START;
                end
            end
            ST_START: if (w_tx_bit_end) begin
                w_tx_tick_next  = '0;
                w_tx_state_next = ST_DATA;
            end
            ST_DATA: if (w_tx_bit_end) begin
                w_tx_tick_next = '0;
                if (r_tx_bit == DATA_LAST) begin
                    w_tx_bit_next   = '0;
                    w_tx_state_next = AFTER_DATA;
                end else begin
                    w_tx_bit_next   = r_tx_bit + 1'b1;
                    w_tx_shift_next = r_tx_shift >> 1;
                end
            end
            ST_PARITY: if (w_tx_bit_end) begin
                w_tx_tick_next  = '0;
                w_tx_state_next = ST_STOP;
            end
            ST_STOP: if (w_tx_bit_end) begin
                w_tx_tick_next = '0;
                if (r_tx_bit == STOP_LAST) begin
                    w_tx_done_next  = 1'b1;
                    w_tx_state_next = ST_IDLE;
                end else begin
                    w_tx_bit_next = r_tx_bit + 1'b1;
                end
            end
            default: w_tx_state_next = ST_IDLE;
        endcase
        // The line is registered from the next state, so a new bit shows up on the edge that enters it.
        case (w_tx_state_next)
            ST_START:  w_tx_line_next = 1'b0;
            ST_DATA:   w_tx_line_next = w_tx_shift_next[0];
            ST_PARITY: w_tx_line_next = w_tx_par_next;
            default:   w_tx_line_next = 1'b1;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_tx_state <= ST_IDLE;
            r_tx_tick  <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_line  <= 1'b1;
            r_tx_done  <= 1'b0;
            r_tx_avail <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_next;
            r_tx_tick  <= w_tx_tick_next;
            r_tx_bit   <= w_tx_bit_next;
            r_tx_shift <= w_tx_shift_next;
            r_tx_par   <= w_tx_par_next;
            r_tx_line  <= w_tx_line_next;
            r_tx_done  <= w_tx_done_next;
            r_tx_avail <= (w_tx_state_next == ST_IDLE);
        end
    end

    // ---------------- receiver ----------------
    logic [1:0]             r_rx_sync;
    logic                   w_rx_line;
    uart_state_t            r_rx_state, w_rx_state_next;
    logic [TICK_CNT_W-1:0]  r_rx_tick,  w_rx_tick_next;
    logic [BIT_CNT_W-1:0]   r_rx_bit,   w_rx_bit_next;
    logic [DATA_WIDTH-1:0]  r_rx_shift, w_rx_shift_next;
    logic                   r_rx_par,   w_rx_par_next;
    logic                   r_rx_err,   w_rx_err_next;
    logic                   r_rx_done,  w_rx_done_next;
    logic [DATA_WIDTH-1:0]  r_rx_data;
    logic                   r_rx_parity;
    logic                   w_rx_bit_end;
    logic                   w_rx_half;

    assign w_rx_line    = r_rx_sync[1];
    assign w_rx_bit_end = w_tick && (r_rx_tick == TICK_LAST);
    assign w_rx_half    = w_tick && (r_rx_tick == TICK_HALF);

    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_tick_next  = w_tick ? r_rx_tick + 1'b1 : r_rx_tick;
        w_rx_bit_next   = r_rx_bit;
        w_rx_shift_next = r_rx_shift;
        w_rx_par_next   = r_rx_par;
        w_rx_err_next   = r_rx_err;
        w_rx_done_next  = 1'b0;
        case (r_rx_state)
            ST_IDLE: begin
                w_rx_tick_next = '0;
                w_rx_bit_next  = '0;
                w_rx_err_next  = 1'b0;
                if (!w_rx_line) w_rx_state_next = ST_START;
            end
            ST_START: if (w_rx_half) begin
                w_rx_tick_next  = '0;
                w_rx_state_next = w_rx_line ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (w_rx_bit_end) begin
                w_rx_tick_next  = '0;
                w_rx_shift_next = {w_rx_line, r_rx_shift[DATA_WIDTH-1:1]};
                if (r_rx_bit == DATA_LAST) begin
                    w_rx_bit_next   = '0;
                    w_rx_state_next = AFTER_DATA;
                end else begin
                    w_rx_bit_next = r_rx_bit + 1'b1;
                end
            end
            ST_PARITY: if (w_rx_bit_end) begin
                w_rx_tick_next  = '0;
                w_rx_par_next   = w_rx_line;
                w_rx_state_next = ST_STOP;
            end
            ST_STOP: begin
                // After a framing error, idle only once the line is high, or a held-low line restarts a frame.
                if (r_rx_err) begin
                    if (w_rx_line) w_rx_state_next = ST_IDLE;
                end else if (w_rx_bit_end) begin
                    w_rx_tick_next = '0;
                    if (!w_rx_line) begin
                        w_rx_err_next = 1'b1;
                    end else if (r_rx_bit == STOP_LAST) begin
                        w_rx_done_next  = 1'b1;
                        w_rx_state_next = ST_IDLE;
                    end else begin
                        w_rx_bit_next = r_rx_bit + 1'b1;
                    end
                end
            end
            default: w_rx_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_rx_sync   <= 2'b11;
            r_rx_state  <= ST_IDLE;
            r_rx_tick   <= '0;
            r_rx_bit    <= '0;
            r_rx_shift  <= '0;
            r_rx_par    <= 1'b0;
            r_rx_err    <= 1'b0;
            r_rx_done   <= 1'b0;
            r_rx_data   <= '0;
            r_rx_parity <= 1'b0;
        end else begin
            r_rx_sync  <= {r_rx_sync[0], i_rx_data};
            r_rx_state <= w_rx_state_next;
            r_rx_tick  <= w_rx_tick_next;
            r_rx_bit   <= w_rx_bit_next;
            r_rx_shift <= w_rx_shift_next;
            r_rx_par   <= w_rx_par_next;
            r_rx_err   <= w_rx_err_next;
            r_rx_done  <= w_rx_done_next;
            if (w_rx_done_next) begin
                r_rx_data   <= w_rx_shift_next;
                r_rx_parity <= w_rx_par_next;
            end
        end
    end

    assign o_tx_data      = r_tx_line;
    assign o_tx_done      = r_tx_done;
    assign o_tx_available = r_tx_avail;
    assign o_rx_done      = r_rx_done;
    assign o_rx_data      = r_rx_data;
    assign o_parity       = PARITY_WIDTH'(r_rx_parity);

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver: TX waveform, loopback, byte stream, glitch, framing error, resets.
module tb_uart_transceiver;

    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_drive = 1'b1;
    logic       loop_en = 1'b0;
    logic       rx_in;
    logic       tx_sig = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic [0:0] par_mode = 1'b0;
    logic       rx_done;
    logic [7:0] rx_data;
    logic [0:0] rx_par;
    logic       tx_line;
    logic       tx_done;
    logic       tx_avail;

    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         rx_cnt = 0;
    int         tx_cnt = 0;
    logic       tx_prev = 1'b1;
    int         tx_edges[$];
    logic [7:0] rx_bytes[$];

    always #5 clk = ~clk;

    assign rx_in = loop_en ? tx_line : rx_drive;

    uart_transceiver dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_rx_data      (rx_in),
        .i_tx_signal    (tx_sig),
        .i_tx_result    (tx_byte),
        .i_parity       (par_mode),
        .o_rx_done      (rx_done),
        .o_rx_data      (rx_data),
        .o_parity       (rx_par),
        .o_tx_data      (tx_line),
        .o_tx_done      (tx_done),
        .o_tx_available (tx_avail)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe counters and line-edge log, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_done) begin
                rx_cnt++;
                rx_bytes.push_back(rx_data);
            end
            if (tx_done) tx_cnt++;
            if (tx_line !== tx_prev) tx_edges.push_back(cyc);
        end
        tx_prev = tx_line;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached after %0d tests", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic kick(input logic [7:0] data, input logic par);
        @(negedge clk);
        tx_byte  = data;
        par_mode = par;
        tx_sig   = 1'b1;
        @(negedge clk);
        tx_sig   = 1'b0;
    endtask

    task automatic wait_tx(input int target, input int budget);
        for (int i = 0; i < budget && tx_cnt < target; i++) @(negedge clk);
    endtask

    task automatic wait_rx(input int target, input int budget);
        for (int i = 0; i < budget && rx_cnt < target; i++) @(negedge clk);
    endtask

    task automatic send_rx_frame(input logic [7:0] data, input logic par, input logic stop);
        logic [10:0] bits;
        bits = {stop, par, data, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx_drive = bits[i];
            wait_clocks(BIT_CLKS);
        end
    endtask

    initial begin
        int          e0;
        int          t0;
        int          r0;
        int          first_len;
        logic [10:0] exp_bits;
        logic [31:0] word;

        // Reset values
        wait_clocks(2);
        check("rst_tx_data", tx_line, 1);
        check("rst_tx_avail", tx_avail, 1);
        check("rst_tx_done", tx_done, 0);
        check("rst_rx_done", rx_done, 0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_parity", rx_par, 0);
        rst_n = 1'b1;
        wait_clocks(5);
        check("post_rst_tx_data", tx_line, 1);

        // TX 0x2B, even parity: start, LSB-first data, parity 0, stop
        exp_bits = {1'b1, 1'b0, 8'h2B, 1'b0};
        e0 = tx_edges.size();
        t0 = tx_cnt;
        kick(8'h2B, 1'b0);
        wait_clocks(32);
        for (int k = 0; k < 11; k++) begin
            check($sformatf("tx2b_bit%0d", k), tx_line, exp_bits[k]);
            if (k == 0 || k == 10) check($sformatf("tx2b_avail_bit%0d", k), tx_avail, 0);
            if (k < 10) wait_clocks(BIT_CLKS);
        end
        wait_tx(t0 + 1, 200);
        wait_clocks(4);
        check("tx2b_done_count", tx_cnt - t0, 1);
        check("tx2b_avail_after", tx_avail, 1);
        check("tx2b_edge_count", tx_edges.size() - e0, 8);
        if (tx_edges.size() - e0 == 8) begin
            first_len = tx_edges[e0 + 1] - tx_edges[e0];
            check("tx2b_start_len_in_61_64", (first_len >= 61 && first_len <= 64), 1);
            check("tx2b_bit_width_d2", tx_edges[e0 + 3] - tx_edges[e0 + 2], BIT_CLKS);
            check("tx2b_width_d6_to_stop", tx_edges[e0 + 7] - tx_edges[e0 + 6], 3 * BIT_CLKS);
        end

        // Loopback 0x08 with odd parity: parity bit on the wire is 0
        loop_en = 1'b1;
        r0 = rx_cnt;
        kick(8'h08, 1'b1);
        wait_rx(r0 + 1, 1000);
        wait_clocks(100);
        check("loop08_rx_count", rx_cnt - r0, 1);
        check("loop08_rx_data", rx_data, 8'h08);
        check("loop08_parity", rx_par, 0);

        // Instruction word streamed LSB byte first at 768-clock spacing
        word = 32'hAC41_0008;
        r0 = rx_cnt;
        for (int b = 0; b < 4; b++) begin
            kick(8'(word >> (8 * b)), 1'b0);
            wait_clocks(766);
        end
        wait_rx(r0 + 4, 1000);
        check("word_rx_count", rx_cnt - r0, 4);
        if (rx_cnt - r0 == 4) begin
            for (int b = 0; b < 4; b++)
                check($sformatf("word_byte%0d", b), rx_bytes[r0 + b], 8'(word >> (8 * b)));
        end
        loop_en = 1'b0;
        wait_clocks(10);

        // 12-clock glitch is rejected by the half-bit check
        r0 = rx_cnt;
        rx_drive = 1'b0;
        wait_clocks(12);
        rx_drive = 1'b1;
        wait_clocks(1000);
        check("glitch_no_rx_done", rx_cnt - r0, 0);
        check("glitch_rx_data_kept", rx_data, 8'hAC);

        // Framing error: stop bit 0, line held low, then released
        send_rx_frame(8'h55, 1'b0, 1'b0);
        wait_clocks(2 * BIT_CLKS);
        rx_drive = 1'b1;
        wait_clocks(200);
        check("frame_err_no_rx_done", rx_cnt - r0, 0);
        check("frame_err_rx_data_kept", rx_data, 8'hAC);

        // Receiver recovers and reports the received parity bit
        send_rx_frame(8'hA5, 1'b1, 1'b1);
        wait_rx(r0 + 1, 300);
        wait_clocks(50);
        check("recover_rx_count", rx_cnt - r0, 1);
        check("recover_rx_data", rx_data, 8'hA5);
        check("recover_parity", rx_par, 1);

        // Request while busy is ignored: one 0x55 frame, 10 line edges
        e0 = tx_edges.size();
        t0 = tx_cnt;
        kick(8'h55, 1'b0);
        wait_clocks(300);
        tx_byte = 8'hFF;
        tx_sig  = 1'b1;
        wait_clocks(3);
        tx_sig  = 1'b0;
        wait_tx(t0 + 1, 600);
        wait_clocks(800);
        check("busy_req_done_count", tx_cnt - t0, 1);
        check("busy_req_edge_count", tx_edges.size() - e0, 10);
        check("busy_req_avail", tx_avail, 1);

        // Reset mid-frame forces the line high and the transmitter idle at once
        kick(8'h00, 1'b0);
        wait_clocks(200);
        check("midrst_line_low_before", tx_line, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_tx_data", tx_line, 1);
        check("midrst_tx_avail", tx_avail, 1);
        check("midrst_tx_done", tx_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clocks(100);
        check("after_midrst_tx_data", tx_line, 1);
        check("after_midrst_avail", tx_avail, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
